// File: rtl/trig_accept_gate.sv
// Trigger accept gate: merges the clock-trigger pulse with prescaled physics
// edges, applies busy and deadtime vetoes, and emits a registered accept pulse
// tagged with its source. Saturating run counters track raw, accepted and
// vetoed activity.
module trig_accept_gate #(
  parameter int CNT_W = 32,
  parameter int PS_W  = 16,
  parameter int DT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_live,
  input  logic             clk_trig,
  input  logic             phys_trig,
  input  logic             busy_in,
  input  logic [PS_W-1:0]  user_prescale,
  input  logic [DT_W-1:0]  user_deadtime,
  output logic             out_trig,
  output logic [1:0]       out_type,
  output logic [CNT_W-1:0] raw_phys_cnt,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] veto_cnt
);

  typedef enum logic {IDLE = 1'b0, DEAD = 1'b1} state_t;

  state_t           state_q;
  logic             phys_d_q;
  logic [PS_W-1:0]  ps_cnt_q;
  logic [DT_W-1:0]  dt_cnt_q;
  logic             out_trig_q;
  logic [1:0]       out_type_q;
  logic [CNT_W-1:0] raw_cnt_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] veto_cnt_q;

  logic             phys_edge;
  logic             phys_cand;
  logic             cand;
  logic [1:0]       cand_type;
  logic             fire;
  logic             veto;
  logic [PS_W:0]    ps_inc;
  logic [PS_W-1:0]  ps_cnt_d;

  // Counters stick at all-ones instead of wrapping so a long run never
  // reports a misleadingly small rate.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Candidate qualification: edge detect, prescale decision, veto split.
  always_comb begin
    phys_edge = phys_trig & ~phys_d_q;
    // A zero prescale blocks physics entirely; ps_cnt then stays parked at 0.
    phys_cand = in_live & phys_edge & (user_prescale != '0) & (ps_cnt_q == '0);
    ps_inc    = {1'b0, ps_cnt_q} + (PS_W+1)'(1);
    ps_cnt_d  = (ps_inc >= {1'b0, user_prescale}) ? '0 : ps_inc[PS_W-1:0];
    cand      = in_live & (clk_trig | phys_cand);
    cand_type = {phys_cand, clk_trig};
    fire      = (state_q == IDLE) & cand & ~busy_in;
    veto      = cand & ((state_q == DEAD) | busy_in);
  end

  // Single-process FSM with registered pulse, type and run counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      phys_d_q   <= 1'b0;
      ps_cnt_q   <= '0;
      dt_cnt_q   <= '0;
      out_trig_q <= 1'b0;
      out_type_q <= 2'b00;
      raw_cnt_q  <= '0;
      acc_cnt_q  <= '0;
      veto_cnt_q <= '0;
    end else begin
      // Edge history tracks the input even while not live, so a level that
      // is already high when live rises is not mistaken for a new event.
      phys_d_q <= phys_trig;
      if (!in_live) begin
        // Dropping live aborts any deadtime in progress; counters are kept.
        state_q    <= IDLE;
        ps_cnt_q   <= '0;
        out_trig_q <= 1'b0;
        out_type_q <= 2'b00;
      end else begin
        if (phys_edge) begin
          raw_cnt_q <= sat_inc(raw_cnt_q);
          ps_cnt_q  <= ps_cnt_d;
        end
        out_trig_q <= fire;
        out_type_q <= fire ? cand_type : 2'b00;
        if (fire)
          acc_cnt_q <= sat_inc(acc_cnt_q);
        if (veto)
          veto_cnt_q <= sat_inc(veto_cnt_q);
        case (state_q)
          IDLE: begin
            if (fire) begin
              dt_cnt_q <= user_deadtime;
              state_q  <= (user_deadtime != '0) ? DEAD : IDLE;
            end
          end
          DEAD: begin
            dt_cnt_q <= dt_cnt_q - DT_W'(1);
            if (dt_cnt_q == DT_W'(1))
              state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_trig     = out_trig_q;
  assign out_type     = out_type_q;
  assign raw_phys_cnt = raw_cnt_q;
  assign acc_cnt      = acc_cnt_q;
  assign veto_cnt     = veto_cnt_q;

endmodule
